// File: rtl/core_pkg.sv
// Shared core types: operand source select used by the decode stage.
package core;
  typedef enum logic [1:0] {
    REG = 2'd0,
    ALU = 2'd1,
    EXE = 2'd2,
    MEM = 2'd3
  } rs_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bundle: decoded instruction fields in, forwarding/stall controls out.
// The decode stage is the master and drives the id_* fields. hazard_ctrl is the slave.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    logic             advance;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_wr;
    logic             id_load;
    logic             flush;
    core::rs_t        rs1_sel;
    core::rs_t        rs2_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output advance, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wr, id_load, flush,
        input  rs1_sel, rs2_sel, stall, stall_cycles
    );

    modport slave (
        input  advance, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wr, id_load, flush,
        output rs1_sel, rs2_sel, stall, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard/forwarding controller: tracks rd/load of the three in-flight
// stages and selects operand sources, stalling on load-use until data reaches memory out.
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    hazard_ctrl_if.slave  hz
);
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } slot_t;

    slot_t            s1, s2, s3;
    slot_t            s1_in;
    logic             capture;
    logic             haz1, haz2;
    logic [CNT_W-1:0] cnt;

    // Returns {hazard, select}; the youngest matching slot wins.
    function automatic logic [2:0] resolve(input logic used, input logic [4:0] rs,
                                           input slot_t a, input slot_t b, input slot_t c);
        logic ok;
        logic [2:0] r;
        ok = used && (rs != 5'd0);
        r  = {1'b0, core::REG};
        if (ok && a.v && (a.rd == rs))      r = {a.ld, core::ALU};
        else if (ok && b.v && (b.rd == rs)) r = {b.ld, core::EXE};
        else if (ok && c.v && (c.rd == rs)) r = {1'b0, core::MEM};
        return r;
    endfunction

    always_comb begin
        logic [2:0] r1, r2;
        r1 = resolve(hz.id_rs1_used, hz.id_rs1, s1, s2, s3);
        r2 = resolve(hz.id_rs2_used, hz.id_rs2, s1, s2, s3);
        haz1       = r1[2];
        haz2       = r2[2];
        hz.rs1_sel = core::rs_t'(r1[1:0]);
        hz.rs2_sel = core::rs_t'(r2[1:0]);
        hz.stall   = hz.id_valid && (haz1 || haz2);
    end

    always_comb begin
        capture  = hz.id_valid && !hz.stall && !hz.flush;
        s1_in.v  = capture && hz.id_wr && (hz.id_rd != 5'd0);
        s1_in.rd = hz.id_rd;
        s1_in.ld = hz.id_load;
    end

    // A flush squashes S1 even when the pipeline is frozen.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            if (hz.advance) begin
                s3 <= s2;
                s2 <= s1;
                s1 <= s1_in;
            end
            if (hz.flush) s1.v <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            cnt <= '0;
        else if (hz.stall && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end

    assign hz.stall_cycles = cnt;
endmodule
